// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state, lamp and direction definitions for the signal-phase arbiter.
package traffic_pkg;

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALL_RED} state_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_W = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_E = 2'd3;

    // Only the served approach can be non-red, so every other head is forced red.
    function automatic logic [2:0] lamp_code(input state_t s, input logic [1:0] ph, input logic [1:0] d);
        return (ph != d) ? LIGHT_RED : (s == GREEN) ? LIGHT_GREEN : (s == YELLOW) ? LIGHT_YELLOW : LIGHT_RED;
    endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// traffic_rr_pick: combinational 4-way round-robin picker, priority start, start+1, start+2, start+3.
module traffic_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic       valid,
    output logic [1:0] index
);

    always_comb begin
        valid = |req;
        index = start;
        for (int i = 3; i >= 0; i--)
            if (req[start + 2'(i)]) index = start + 2'(i);
    end

endmodule

// File: rtl/traffic_phase_arbiter.sv
// traffic_phase_arbiter: round-robin four-approach green/yellow/all-red sequencer with registered lamps.
// Optional emergency preemption enabled by defining PREEMPT_EN.
module traffic_phase_arbiter
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    output logic [2:0]       north_light,
    output logic [2:0]       west_light,
    output logic [2:0]       south_light,
    output logic [2:0]       east_light,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] count
`ifdef PREEMPT_EN
    ,
    input  logic             preempt,
    input  logic [1:0]       preempt_dir
`endif
);

    state_t           r_state, w_state_nx;
    logic [1:0]       r_phase, w_phase_nx, r_ptr, w_ptr_nx;
    logic [CNT_W-1:0] r_count, w_count_nx;
    logic             r_pre, w_pre_nx;
    logic [3:0][2:0]  r_lights, w_lights_nx;
    logic             w_pre, w_valid, w_own, w_other, w_sat;
    logic [1:0]       w_pdir, w_base, w_pick;

`ifdef PREEMPT_EN
    assign w_pre  = preempt;
    assign w_pdir = preempt_dir;
`else
    assign w_pre  = 1'b0;
    assign w_pdir = DIR_N;
`endif

    // A preempted green must not move the pointer, so its all-red exit keeps the old one.
    assign w_base  = (r_state == ALL_RED && !r_pre) ? r_phase : r_ptr;
    assign w_own   = req[r_phase];
    assign w_other = |(req & ~(4'b0001 << r_phase));
    assign w_sat   = r_count == CNT_W'(GREEN_MAX - 1);

    traffic_rr_pick u_pick (
        .req   (req),
        .start (w_base + 2'd1),
        .valid (w_valid),
        .index (w_pick)
    );

    always_comb begin
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_ptr_nx   = r_ptr;
        w_pre_nx   = r_pre;
        w_count_nx = r_count;
        case (r_state)
            IDLE: begin
                w_count_nx = '0;
                if (w_pre || w_valid) begin
                    w_state_nx = GREEN;
                    w_phase_nx = w_pre ? w_pdir : w_pick;
                    w_pre_nx   = w_pre;
                end
            end
            GREEN: begin
                if (w_pre && r_phase == w_pdir) begin
                    w_count_nx = r_count;
                end else if (w_pre || (w_other && (w_sat || (r_count >= CNT_W'(GREEN_MIN - 1) && !w_own)))) begin
                    w_state_nx = YELLOW;
                    w_count_nx = '0;
                end else begin
                    w_count_nx = w_sat ? r_count : r_count + 1'b1;
                end
            end
            YELLOW: begin
                w_state_nx = (r_count == CNT_W'(YELLOW_T - 1)) ? ALL_RED : YELLOW;
                w_count_nx = (r_count == CNT_W'(YELLOW_T - 1)) ? '0 : r_count + 1'b1;
            end
            ALL_RED: begin
                w_count_nx = r_count + 1'b1;
                if (r_count == CNT_W'(ALLRED_T - 1)) begin
                    w_count_nx = '0;
                    w_ptr_nx   = w_base;
                    w_state_nx = (w_pre || w_valid) ? GREEN : IDLE;
                    w_phase_nx = w_pre ? w_pdir : w_valid ? w_pick : r_phase;
                    w_pre_nx   = w_pre;
                end
            end
            default: w_state_nx = IDLE;
        endcase
        for (int i = 0; i < 4; i++)
            w_lights_nx[i] = lamp_code(w_state_nx, w_phase_nx, 2'(i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_phase  <= DIR_N;
            r_ptr    <= DIR_E;
            r_count  <= '0;
            r_pre    <= 1'b0;
            r_lights <= {4{LIGHT_RED}};
        end else begin
            r_state  <= w_state_nx;
            r_phase  <= w_phase_nx;
            r_ptr    <= w_ptr_nx;
            r_count  <= w_count_nx;
            r_pre    <= w_pre_nx;
            r_lights <= w_lights_nx;
        end
    end

    assign north_light = r_lights[DIR_N];
    assign west_light  = r_lights[DIR_W];
    assign south_light = r_lights[DIR_S];
    assign east_light  = r_lights[DIR_E];
    assign phase       = r_phase;
    assign count       = r_count;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// tb_traffic_phase_arbiter: directed checks of phase sequencing, timing and reset for traffic_phase_arbiter.
module tb_traffic_phase_arbiter;

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [2:0] north_light, west_light, south_light, east_light;
    logic [1:0] phase;
    logic [3:0] count;
    int         n_tests = 0;
    int         n_fail = 0;
`ifdef PREEMPT_EN
    logic       preempt = 1'b0;
    logic [1:0] preempt_dir = 2'd0;
`endif

    traffic_phase_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .north_light (north_light),
        .west_light  (west_light),
        .south_light (south_light),
        .east_light  (east_light),
        .phase       (phase),
        .count       (count)
`ifdef PREEMPT_EN
        ,
        .preempt     (preempt),
        .preempt_dir (preempt_dir)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] lamp(input logic [2:0] code, input int d);
        logic [11:0] r;
        r = 12'h924;
        r[d*3 +: 3] = code;
        return r;
    endfunction

    function automatic int nonred();
        return int'(north_light != R) + int'(west_light != R) + int'(south_light != R) + int'(east_light != R);
    endfunction

    task automatic step(input string tag, input logic [11:0] exp_l, input int exp_c);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_lamps"}, int'({east_light, south_light, west_light, north_light}), int'(exp_l));
        check({tag, "_count"}, int'(count), exp_c);
        check({tag, "_one_lit"}, int'(nonred() <= 1), 1);
    endtask

    task automatic run_phase(input string tag, input int d, input int from, input int len);
        for (int i = from; i < len; i++) begin
            step({tag, "_green"}, lamp(G, d), i);
            if (i == from) check({tag, "_phase"}, int'(phase), d);
        end
        step({tag, "_yel0"}, lamp(Y, d), 0);
        step({tag, "_yel1"}, lamp(Y, d), 1);
        step({tag, "_allred"}, 12'h924, 0);
    endtask

    task automatic do_reset(input string tag, input logic [3:0] r);
        reset = 1'b1;
        req = r;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_rst_lamps"}, int'({east_light, south_light, west_light, north_light}), 12'h924);
        check({tag, "_rst_count"}, int'(count), 0);
        check({tag, "_rst_phase"}, int'(phase), 0);
        reset = 1'b0;
    endtask

    initial begin
        do_reset("all", 4'b1111);
        run_phase("all_n", 0, 0, 8);
        run_phase("all_w", 1, 0, 8);
        run_phase("all_s", 2, 0, 8);
        run_phase("all_e", 3, 0, 8);
        step("all_n2", lamp(G, 0), 0);

        do_reset("sat", 4'b0001);
        for (int i = 0; i < 20; i++) step("sat", lamp(G, 0), (i < 7) ? i : 7);

        do_reset("ns", 4'b0101);
        run_phase("ns_n", 0, 0, 8);
        run_phase("ns_s", 2, 0, 8);
        run_phase("ns_n2", 0, 0, 8);
        step("ns_s2", lamp(G, 2), 0);

        do_reset("gap", 4'b0011);
        step("gap_n0", lamp(G, 0), 0);
        step("gap_n1", lamp(G, 0), 1);
        req = 4'b0010;
        run_phase("gap_n", 0, 2, 4);
        step("gap_w0", lamp(G, 1), 0);
        check("gap_w_phase", int'(phase), 1);
        step("gap_w1", lamp(G, 1), 1);

        do_reset("ry", 4'b0101);
        for (int i = 0; i < 8; i++) step("ry_green", lamp(G, 0), i);
        step("ry_yel0", lamp(Y, 0), 0);
        step("ry_yel1", lamp(Y, 0), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ry_lamps", int'({east_light, south_light, west_light, north_light}), 12'h924);
        check("ry_count", int'(count), 0);
        check("ry_phase", int'(phase), 0);
        reset = 1'b0;
        step("ry_restart", lamp(G, 0), 0);

`ifdef PREEMPT_EN
        do_reset("pre", 4'b0001);
        step("pre_n0", lamp(G, 0), 0);
        step("pre_n1", lamp(G, 0), 1);
        preempt = 1'b1;
        preempt_dir = 2'd3;
        req = 4'b0000;
        step("pre_yel0", lamp(Y, 0), 0);
        step("pre_yel1", lamp(Y, 0), 1);
        step("pre_allred", 12'h924, 0);
        step("pre_e0", lamp(G, 3), 0);
        step("pre_e_hold", lamp(G, 3), 0);
        preempt = 1'b0;
        step("pre_e_run", lamp(G, 3), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
